axi_mem_responder: RTL
======================

AXI_MEM_RESPONDER -- requirements
Module: axi_mem_responder

Interface
REQ-001 SHALL have parameter AXI_ADDR_W, default 32, AXI and memory byte-address width.
REQ-002 SHALL have parameter AXI_ID_W, default 1, AXI ID width; data width fixed at 32 bits (4 byte lanes).
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port s_axi_awid  input  AXI_ID_W  write burst ID.
REQ-006 SHALL have port s_axi_awaddr  input  AXI_ADDR_W  write burst start byte address.
REQ-007 SHALL have port s_axi_awlen  input  8  write beats minus one.
REQ-008 SHALL have port s_axi_awvalid  input  1  write address valid.
REQ-009 SHALL have port s_axi_awready  output  1  write address accepted.
REQ-010 SHALL have port s_axi_wdata  input  32  write beat data.
REQ-011 SHALL have port s_axi_wstrb  input  4  write byte enables.
REQ-012 SHALL have port s_axi_wlast  input  1  initiator's last-beat marker.
REQ-013 SHALL have port s_axi_wvalid  input  1  write data valid.
REQ-014 SHALL have port s_axi_wready  output  1  write data accepted.
REQ-015 SHALL have port s_axi_bid  output  AXI_ID_W  captured awid.
REQ-016 SHALL have port s_axi_bresp  output  2  2'b00 OKAY, 2'b10 SLVERR.
REQ-017 SHALL have port s_axi_bvalid  output  1  write response valid.
REQ-018 SHALL have port s_axi_bready  input  1  write response accepted.
REQ-019 SHALL have port s_axi_arid  input  AXI_ID_W  read burst ID.
REQ-020 SHALL have port s_axi_araddr  input  AXI_ADDR_W  read burst start byte address.
REQ-021 SHALL have port s_axi_arlen  input  8  read beats minus one.
REQ-022 SHALL have port s_axi_arvalid  input  1  read address valid.
REQ-023 SHALL have port s_axi_arready  output  1  read address accepted.
REQ-024 SHALL have port s_axi_rid  output  AXI_ID_W  captured arid.
REQ-025 SHALL have port s_axi_rdata  output  32  read beat data.
REQ-026 SHALL have port s_axi_rresp  output  2  always 2'b00.
REQ-027 SHALL have port s_axi_rlast  output  1  high on final read beat.
REQ-028 SHALL have port s_axi_rvalid  output  1  read data valid.
REQ-029 SHALL have port s_axi_rready  input  1  read data accepted.
REQ-030 SHALL have inputs s_axi_{aw,ar}{size(3),burst(2),lock(2),cache(4),prot(3),qos(4)}, ignored; every burst treated as INCR, 4-byte beats.
REQ-031 SHALL have port mem_valid  output  1  memory request, held until mem_ready.
REQ-032 SHALL have port mem_addr  output  AXI_ADDR_W  word address, bits [1:0] always 0.
REQ-033 SHALL have port mem_wdata  output  32  write data.
REQ-034 SHALL have port mem_wstrb  output  4  byte enables; 4'h0 means read.
REQ-035 SHALL have port mem_rdata  input  32  read data, valid when mem_ready high.
REQ-036 SHALL have port mem_ready  input  1  request completed this cycle (may be same cycle as mem_valid).

Function
REQ-037 SHALL implement FSM IDLE, WDATA, WMEM, WRESP, RMEM, RDATA; one burst in flight; awready/arready high only in IDLE (combinational on valid); awvalid wins when both valid in same cycle.
REQ-038 SHALL on AW handshake capture {awaddr[AW-1:2],2'b00}, awlen, awid, clear beat counter and error flag -> WDATA; wready=1 only in WDATA; each W handshake registers wdata/wstrb -> WMEM, except wstrb==4'h0, which skips memory, advances address and counter that cycle.
REQ-039 SHALL in WMEM drive mem_valid with stable addr/wdata/wstrb; on mem_ready: address+=4 (mod 2^AXI_ADDR_W, no 4 KB check), counter+=1; if counter==len -> WRESP else WDATA.
REQ-040 SHALL set error flag when wlast is high on a beat with counter!=len or low on counter==len; burst still consumes exactly len+1 beats; WRESP drives bvalid, bresp=error?2'b10:2'b00, bid; bready -> IDLE.
REQ-041 SHALL on AR handshake capture aligned address, arlen, arid -> RMEM (mem_valid, wstrb=0); mem_ready registers mem_rdata into s_axi_rdata -> RDATA; rvalid=1, rlast=(counter==len); rdata stable while rready low; on rready: last -> IDLE else address+=4, counter+=1 -> RMEM.

Reset
REQ-042 SHALL on rst asynchronously force IDLE, all valid/ready/last outputs 0, bresp/rresp 0, rdata/bid/rid/mem_addr/mem_wdata/mem_wstrb 0; any burst in progress discarded with no B/R completion.

Verification
REQ-043 SHALL cover: awaddr=0x100, awlen=3, wstrb=4'hF, data 0x11111111..0x44444444 -> mem writes at 0x100,0x104,0x108,0x10C, bresp=00, bid=awid, wready never high while mem_valid.
REQ-044 SHALL cover: araddr=0x102, arlen=0, mem_rdata=0xCAFEF00D -> mem_addr=0x100, one R beat rdata=0xCAFEF00D, rlast=1, rresp=00.
REQ-045 SHALL cover: awvalid and arvalid same cycle in IDLE -> write accepted first, arready stays 0 until B handshake, then read served.
REQ-046 SHALL cover: awaddr=0x0, awlen=2, beat1 wstrb=4'h0 -> only two mem_valid accesses, at 0x0 and 0x8; bresp=00.
REQ-047 SHALL cover: awlen=1 with wlast=1 on beat0 -> two beats still accepted, bresp=2'b10; then rst asserted during RDATA with rready=0 -> rvalid=0 immediately, next arvalid accepted.

Source files
------------

// File: rtl/axi_mem_responder.sv
// AXI4 slave that serialises one INCR burst at a time onto a simple
// valid/ready word-wide memory port; 32-bit data, ignores size/burst/cache hints.
`timescale 1ns/1ps
module axi_mem_responder #(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_ID_W   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [AXI_ID_W-1:0]   s_axi_awid,
  input  logic [AXI_ADDR_W-1:0] s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic [2:0]            s_axi_awsize,
  input  logic [1:0]            s_axi_awburst,
  input  logic [1:0]            s_axi_awlock,
  input  logic [3:0]            s_axi_awcache,
  input  logic [2:0]            s_axi_awprot,
  input  logic [3:0]            s_axi_awqos,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [31:0]           s_axi_wdata,
  input  logic [3:0]            s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [AXI_ID_W-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [AXI_ID_W-1:0]   s_axi_arid,
  input  logic [AXI_ADDR_W-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic [1:0]            s_axi_arlock,
  input  logic [3:0]            s_axi_arcache,
  input  logic [2:0]            s_axi_arprot,
  input  logic [3:0]            s_axi_arqos,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [AXI_ID_W-1:0]   s_axi_rid,
  output logic [31:0]           s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic                  mem_valid,
  output logic [AXI_ADDR_W-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ready
);

  typedef enum logic [2:0] {
    S_IDLE, S_WDATA, S_WMEM, S_WRESP, S_RMEM, S_RDATA
  } state_t;

  state_t                state_q, state_d;
  logic [AXI_ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [AXI_ID_W-1:0]   id_q, id_d;
  logic                  err_q, err_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic [31:0]           rdata_q, rdata_d;

  logic                  last_beat;
  logic [AXI_ADDR_W-1:0] addr_inc;
  logic                  unused_inputs;

  assign last_beat = (cnt_q == len_q);
  assign addr_inc  = addr_q + AXI_ADDR_W'(4);

  // Burst attributes are fixed (INCR, 4-byte beats), so these inputs carry no information.
  assign unused_inputs = ^{s_axi_awsize, s_axi_awburst, s_axi_awlock, s_axi_awcache,
                           s_axi_awprot, s_axi_awqos, s_axi_awaddr[1:0],
                           s_axi_arsize, s_axi_arburst, s_axi_arlock, s_axi_arcache,
                           s_axi_arprot, s_axi_arqos, s_axi_araddr[1:0]};

  // Address channels accept only while idle; a simultaneous write wins over the read.
  assign s_axi_awready = !rst && (state_q == S_IDLE) && s_axi_awvalid;
  assign s_axi_arready = !rst && (state_q == S_IDLE) && s_axi_arvalid && !s_axi_awvalid;
  assign s_axi_wready  = (state_q == S_WDATA);

  assign s_axi_bvalid  = (state_q == S_WRESP);
  assign s_axi_bresp   = (s_axi_bvalid && err_q) ? 2'b10 : 2'b00;
  assign s_axi_bid     = id_q;

  assign s_axi_rvalid  = (state_q == S_RDATA);
  assign s_axi_rlast   = s_axi_rvalid && last_beat;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = 2'b00;
  assign s_axi_rid     = id_q;

  assign mem_valid     = (state_q == S_WMEM) || (state_q == S_RMEM);
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign mem_wstrb     = (state_q == S_WMEM) ? wstrb_q : 4'h0;

  always_comb begin
    // NOTE: every _d defaults to its _q first so no path through the case infers a latch.
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    err_d   = err_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (s_axi_awvalid) begin
          addr_d  = {s_axi_awaddr[AXI_ADDR_W-1:2], 2'b00};
          len_d   = s_axi_awlen;
          id_d    = s_axi_awid;
          cnt_d   = 8'd0;
          err_d   = 1'b0;
          state_d = S_WDATA;
        end else if (s_axi_arvalid) begin
          addr_d  = {s_axi_araddr[AXI_ADDR_W-1:2], 2'b00};
          len_d   = s_axi_arlen;
          id_d    = s_axi_arid;
          cnt_d   = 8'd0;
          state_d = S_RMEM;
        end
      end
      S_WDATA: begin
        if (s_axi_wvalid) begin
          if (s_axi_wlast != last_beat) err_d = 1'b1;
          // A beat with no enabled lanes never reaches memory but still occupies its slot.
          if (s_axi_wstrb == 4'h0) begin
            addr_d  = addr_inc;
            cnt_d   = cnt_q + 8'd1;
            state_d = last_beat ? S_WRESP : S_WDATA;
          end else begin
            wdata_d = s_axi_wdata;
            wstrb_d = s_axi_wstrb;
            state_d = S_WMEM;
          end
        end
      end
      S_WMEM: begin
        if (mem_ready) begin
          addr_d  = addr_inc;
          cnt_d   = cnt_q + 8'd1;
          state_d = last_beat ? S_WRESP : S_WDATA;
        end
      end
      S_WRESP: if (s_axi_bready) state_d = S_IDLE;
      S_RMEM: begin
        if (mem_ready) begin
          rdata_d = mem_rdata;
          state_d = S_RDATA;
        end
      end
      S_RDATA: begin
        if (s_axi_rready) begin
          if (last_beat) begin
            state_d = S_IDLE;
          end else begin
            addr_d  = addr_inc;
            cnt_d   = cnt_q + 8'd1;
            state_d = S_RMEM;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      id_q    <= '0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
    end else begin
      // NOTE: non-blocking updates keep every flop sampling pre-edge values of the others.
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      err_q   <= err_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
    end
  end

endmodule
